mxint8_block_quantizer: RTL and testbench

- Streaming FP32-to-MXINT8 block quantizer. Collects BLOCK_SIZE scalar FP32 values, one per accepted beat, and derives the shared block scale as the maximum biased exponent.
- Quantizes every element against that shared scale to 8-bit two's-complement, using round-to-nearest-even (RNE).
- Emits one complete MX block (scale plus packed elements) through a valid/ready handshake. Sits downstream of the FP32 datapath and upstream of the MX ALU operand buffers.

---
 rtl/mxint8_block_quantizer_if.sv | 27 ++
 rtl/mxint8_block_quantizer.sv | 139 +++++++++++++
 tb/tb_mxint8_block_quantizer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mxint8_block_quantizer_if.sv
// Stream interface for the MXINT8 block quantizer: FP32 beats in, one packed MX block out.
// The master side drives input beats and downstream ready; the slave side is the quantizer.
interface mxint8_block_quantizer_if #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8
);
    logic                             i_valid;
    logic                             o_ready;
    logic [31:0]                      i_float32;
    logic                             o_valid;
    logic                             i_ready;
    logic [SCALE_WIDTH-1:0]           o_scale;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_mxint8_elements;
    logic                             o_nan;
    logic                             o_sat;

    modport master (
        output i_valid, i_float32, i_ready,
        input  o_ready, o_valid, o_scale, o_mxint8_elements, o_nan, o_sat
    );

    modport slave (
        input  i_valid, i_float32, i_ready,
        output o_ready, o_valid, o_scale, o_mxint8_elements, o_nan, o_sat
    );
endinterface

// File: rtl/mxint8_block_quantizer.sv
// Streaming FP32 -> MXINT8 block quantizer: buffers a block, takes the max exponent as the
// shared E8M0 scale, then quantizes one element per cycle with round-to-nearest-even.
module mxint8_block_quantizer #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    mxint8_block_quantizer_if.slave bus
);
    localparam int              CNT_W    = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {FILL, QUANT, OUT} state_t;

    state_t                           r_state;
    logic [CNT_W-1:0]                 r_cnt;
    logic [7:0]                       r_maxExp;
    logic                             r_nan;
    logic                             r_sat;
    logic                             r_ready;
    logic                             r_valid;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] r_elems;
    logic [31:0]                      r_mem [BLOCK_SIZE];

    logic                  w_accept;
    logic [7:0]            w_inExp;
    logic [31:0]           w_word;
    logic [7:0]            w_exp;
    logic [23:0]           w_mant;
    logic [8:0]            w_diff;
    logic [8:0]            w_shiftFull;
    logic [4:0]            w_shift;
    logic [55:0]           w_ext;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_inc;
    logic [23:0]           w_magRound;
    logic                  w_clamp;
    logic                  w_zero;
    logic [ELEM_WIDTH-1:0] w_mag;
    logic [ELEM_WIDTH-1:0] w_elem;

    assign w_accept = r_ready && bus.i_valid;
    assign w_inExp  = bus.i_float32[30:23];

    // Element value relative to the block scale is m * 2^-(d+17); the low 32 bits of w_ext
    // hold what was shifted out, so guard and sticky come straight from them.
    assign w_word      = r_mem[r_cnt];
    assign w_exp       = w_word[30:23];
    assign w_mant      = {1'b1, w_word[22:0]};
    assign w_diff      = {1'b0, r_maxExp} - {1'b0, w_exp};
    assign w_shiftFull = w_diff + 9'd17;
    assign w_shift     = (w_shiftFull > 9'd31) ? 5'd31 : w_shiftFull[4:0];
    assign w_ext       = {w_mant, 32'd0} >> w_shift;
    assign w_guard     = w_ext[31];
    assign w_sticky    = |w_ext[30:0];
    assign w_inc       = w_guard && (w_sticky || w_ext[32]);
    assign w_magRound  = w_ext[55:32] + {23'd0, w_inc};
    assign w_clamp     = (w_magRound > 24'd127) && !w_zero;
    assign w_zero      = (w_exp == 8'd0) || r_nan;
    assign w_mag       = (w_magRound > 24'd127) ? ELEM_WIDTH'(127) : w_magRound[ELEM_WIDTH-1:0];
    assign w_elem      = w_zero ? '0 : (w_word[31] ? -w_mag : w_mag);

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_accept) begin
            r_mem[r_cnt] <= bus.i_float32;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= FILL;
            r_cnt    <= '0;
            r_maxExp <= '0;
            r_nan    <= 1'b0;
            r_sat    <= 1'b0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_elems  <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_inExp > r_maxExp) begin
                            r_maxExp <= w_inExp;
                        end
                        if (w_inExp == 8'hFF) begin
                            r_nan <= 1'b1;
                        end
                        if (r_cnt == LAST_IDX) begin
                            r_state <= QUANT;
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                QUANT: begin
                    r_elems[r_cnt*ELEM_WIDTH +: ELEM_WIDTH] <= w_elem;
                    r_sat <= r_sat || w_clamp;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= OUT;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.i_ready) begin
                        r_state  <= FILL;
                        r_valid  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_maxExp <= '0;
                        r_nan    <= 1'b0;
                        r_sat    <= 1'b0;
                        r_elems  <= '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Data outputs read as zero whenever no block is being presented.
    assign bus.o_ready           = r_ready;
    assign bus.o_valid           = r_valid;
    assign bus.o_scale           = r_valid ? (r_nan ? '1 : SCALE_WIDTH'(r_maxExp)) : '0;
    assign bus.o_mxint8_elements = r_valid ? r_elems : '0;
    assign bus.o_nan             = r_valid && r_nan;
    assign bus.o_sat             = r_valid && r_sat;
endmodule

// File: tb/tb_mxint8_block_quantizer.sv
// Self-checking bench for mxint8_block_quantizer: directed and random FP32 blocks compared
// against an arithmetic reference model of MXINT8 quantization.
module tb_mxint8_block_quantizer;
    localparam int BS = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cycleNum = 0;
    int   lastBeatCycle = 0;

    logic [31:0]  blockWords [BS];
    logic [7:0]   expScale;
    logic [255:0] expElems;
    logic         expNan;
    logic         expSat;

    always #5 clk = ~clk;
    always @(posedge clk) cycleNum <= cycleNum + 1;

    mxint8_block_quantizer_if #(.BLOCK_SIZE(BS)) bus();

    mxint8_block_quantizer #(.BLOCK_SIZE(BS)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: element = RNE(value / 2^(Emax-127-6)), done with integer division.
    task automatic computeReference();
        int     emax;
        bit     nan;
        int     e;
        int     k;
        longint m;
        longint den;
        longint q;
        longint r;
        logic [7:0] v;
        emax = 0;
        nan = 1'b0;
        for (int i = 0; i < BS; i++) begin
            e = int'(blockWords[i][30:23]);
            if (e == 255) nan = 1'b1;
            if (e > emax) emax = e;
        end
        expSat = 1'b0;
        expElems = '0;
        expNan = nan;
        if (nan) begin
            expScale = 8'hFF;
        end else begin
            expScale = 8'(emax);
            for (int i = 0; i < BS; i++) begin
                e = int'(blockWords[i][30:23]);
                if (e != 0) begin
                    m = longint'({1'b1, blockWords[i][22:0]});
                    k = emax - e + 17;
                    if (k > 40) begin
                        q = 0;
                    end else begin
                        den = longint'(1) << k;
                        q = m / den;
                        r = m % den;
                        if ((2 * r > den) || ((2 * r == den) && (q % 2 == 1))) q = q + 1;
                    end
                    if (q > 127) begin
                        q = 127;
                        expSat = 1'b1;
                    end
                    v = 8'(q);
                    if (blockWords[i][31]) v = -v;
                    expElems[8*i +: 8] = v;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int gapMax, input int count);
        for (int i = 0; i < count; i++) begin
            int tries;
            bit done;
            tries = 0;
            done = 1'b0;
            repeat ($urandom_range(0, gapMax)) begin
                bus.i_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.i_valid = 1'b1;
            bus.i_float32 = blockWords[i];
            while (!done) begin
                done = bus.o_ready;
                lastBeatCycle = cycleNum;
                @(posedge clk); #1;
                tries++;
                if (!done && tries > 200) begin
                    checkOutput("readyTimeout", 1'b0, 1'b1);
                    done = 1'b1;
                end
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic checkBlock(input int holdCycles, input bit checkLatency);
        int tries;
        tries = 0;
        bus.i_ready = (holdCycles == 0);
        computeReference();
        while (!bus.o_valid && tries < 100) begin
            @(posedge clk); #1;
            tries++;
        end
        checkOutput("validSeen", bus.o_valid, 1'b1);
        if (checkLatency) checkOutput("latency", cycleNum - lastBeatCycle, 33);
        checkOutput("scale", bus.o_scale, expScale);
        checkOutput("elements", bus.o_mxint8_elements, expElems);
        checkOutput("nan", bus.o_nan, expNan);
        checkOutput("sat", bus.o_sat, expSat);
        checkOutput("readyLowOut", bus.o_ready, 1'b0);
        repeat (holdCycles) begin
            @(posedge clk); #1;
            checkOutput("holdValid", bus.o_valid, 1'b1);
            checkOutput("holdScale", bus.o_scale, expScale);
            checkOutput("holdElements", bus.o_mxint8_elements, expElems);
            checkOutput("holdNan", bus.o_nan, expNan);
            checkOutput("holdSat", bus.o_sat, expSat);
            checkOutput("holdReady", bus.o_ready, 1'b0);
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        checkOutput("dropValid", bus.o_valid, 1'b0);
        checkOutput("dropScale", bus.o_scale, 8'h00);
        checkOutput("dropElements", bus.o_mxint8_elements, 256'd0);
        checkOutput("readyBack", bus.o_ready, 1'b1);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstValid", bus.o_valid, 1'b0);
        checkOutput("rstReady", bus.o_ready, 1'b1);
        checkOutput("rstElements", bus.o_mxint8_elements, 256'd0);
        rst = 1'b0;
    endtask

    task automatic fillAll(input logic [31:0] w);
        for (int i = 0; i < BS; i++) blockWords[i] = w;
    endtask

    task automatic randomBlock();
        int baseExp;
        int e;
        baseExp = $urandom_range(40, 200);
        for (int i = 0; i < BS; i++) begin
            blockWords[i][31] = 1'($urandom_range(0, 1));
            blockWords[i][22:0] = 23'($urandom);
            e = baseExp - int'($urandom_range(0, 28));
            if ($urandom_range(0, 9) == 0) e = 0;
            blockWords[i][30:23] = 8'(e);
        end
        if ($urandom_range(0, 5) == 0) blockWords[$urandom_range(0, BS-1)][30:23] = 8'hFF;
    endtask

    initial begin
        $display("[TB] starting mxint8_block_quantizer bench");
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_float32 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", bus.o_valid, 1'b0);
        checkOutput("resetReady", bus.o_ready, 1'b1);
        checkOutput("resetScale", bus.o_scale, 8'h00);
        checkOutput("resetElements", bus.o_mxint8_elements, 256'd0);
        checkOutput("resetNan", bus.o_nan, 1'b0);
        checkOutput("resetSat", bus.o_sat, 1'b0);
        rst = 1'b0;

        fillAll(32'h3F800000);
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h3F800000);
        blockWords[0] = 32'h40000000;
        blockWords[1] = 32'hBFC00000;
        applyStimulus(1, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h3F800000);
        blockWords[1] = 32'h3C000000;
        blockWords[2] = 32'h3C400000;
        blockWords[3] = 32'h3FFF0000;
        blockWords[4] = 32'hBFFF0000;
        blockWords[5] = 32'hBC400000;
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h3F800000);
        blockWords[7] = 32'h7FC00000;
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h00000000);
        blockWords[3] = 32'h80000000;
        blockWords[9] = 32'h00000001;
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h47000000);
        applyStimulus(0, BS);
        checkBlock(5, 1'b1);
        fillAll(32'h3E000000);
        blockWords[0] = 32'hBE400000;
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h40800000);
        applyStimulus(0, 10);
        applyReset();
        fillAll(32'h3F800000);
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        fillAll(32'h40800000);
        applyStimulus(0, BS);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("quantReadyLow", bus.o_ready, 1'b0);
        applyReset();
        fillAll(32'h3F800000);
        applyStimulus(0, BS);
        checkBlock(0, 1'b1);

        for (int n = 0; n < 20; n++) begin
            randomBlock();
            applyStimulus(2, BS);
            checkBlock(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
